packet_sink_mc: RTL and testbench
=================================

# packet_sink_mc

Multi-channel packet sink terminating up to CHANNELS NoC output channels at the edge of the mesh or in a test harness. Each channel accepts flits over a req/ack handshake, tracks packet framing, and checks head-flit destinations against its own ID. It also reports per-packet length and keeps aggregate packet, flit and error counters. It succeeds the single-channel sink and adds framing checks, statistics and back-pressure control.

## Interface
- CHANNELS, 4: number of independent input channels (1..16).
- ID, 0: node ID; channel i expects destination ID+i in head flits.
- SIZE, 8: flit width in bits (≥ DEST_BITS+2).
- DEST_BITS, 4: width of destination field in head flits.
- LEN_BITS, 6: packet-length field width.
- CNT_BITS, 16: statistics counter width.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = sink may accept flits; 0 = stall all channels.
- clear  in  1  synchronous clear of counters and framing state.
- ch_req  in  CHANNELS  flit valid per channel.
- ch_flit  in  CHANNELS*SIZE  channel i at [i*SIZE +: SIZE].
- ch_ack  out  CHANNELS  sink ready per channel (registered).
- pkt_done  out  CHANNELS  one-cycle pulse: packet completed on channel i.
- pkt_len  out  CHANNELS*LEN_BITS  length in flits of last completed packet, channel i at [i*LEN_BITS +: LEN_BITS].
- pkt_count  out  CNT_BITS  total packets completed.
- flit_count  out  CNT_BITS  total flits accepted.
- err_count  out  CNT_BITS  total framing/destination errors.

## Operation
- Flit format: bit SIZE-1 = HEAD, bit SIZE-2 = TAIL, bits [DEST_BITS-1:0] = destination (head flits only).
- Transfer on channel i at a rising edge where ch_req[i]=1 and ch_ack[i]=1. Sender holds ch_flit stable while ch_req=1 and ch_ack=0.
- ch_ack[i] next = enable & ~clear (& ~throttle[i] when configured). It does not depend on ch_req.
- Per-channel FSM, states IDLE and BODY:
  - IDLE, HEAD&TAIL: single-flit packet; pkt_done pulse, len=1; stay IDLE.
  - IDLE, HEAD only: len=1 → BODY.
  - IDLE, non-head: error +1, flit discarded; stay IDLE.
  - BODY, plain flit: len+1, saturating at 2^LEN_BITS-1.
  - BODY, TAIL: len+1 (saturating); pkt_done pulse → IDLE.
  - BODY, HEAD: error +1 (truncated packet); new packet starts, len=1. With TAIL also set: complete it as a single-flit packet → IDLE; otherwise stay BODY.
- Destination mismatch on a head flit (dest ≠ (ID+i) mod 2^DEST_BITS): error +1; the packet is still tracked and counted. A head flit that is both out of place and misrouted counts 2.
- Counters:
  - flit_count adds the popcount of transfers in the cycle.
  - pkt_count adds the popcount of completions in the cycle.
  - Both wrap modulo 2^CNT_BITS.
  - err_count adds that cycle's errors and saturates at all-ones.
- clear=1: all FSMs → IDLE, all counters → 0, pkt_len → 0. Transfers on that edge are consumed but not counted or checked. clear has priority over transfers.
- enable=0 does not alter FSM state; a packet in progress resumes when enable returns.

## Timing
- Reset values: ch_ack=0, pkt_done=0, pkt_len=0, all counters 0, FSMs IDLE, throttle LFSRs at seed.
- ch_ack rises one cycle after enable=1 is sampled and falls one cycle after enable=0 or clear=1.
- Throughput is 1 flit/cycle/channel when unthrottled.
- pkt_done, pkt_len and counters update on the same edge that captures the completing flit, visible the following cycle. pkt_done lasts exactly one cycle.
- Reset assertion mid-packet abandons the packet immediately, with no pulse and no error.

## Configuration
- PACKET_SINK_THROTTLE_EN defined: each channel has an 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded with ((ID+i) mod 255)+1, advancing every cycle. throttle[i] = LFSR[1:0]==0, so ack is withheld about 25% of cycles to stress upstream back-pressure.
- Undefined: no LFSRs, throttle[i]=0, and ch_ack follows enable & ~clear.

## Test plan
- Reset, enable=1, channel 0 sends HEAD(dest=ID), BODY, BODY, TAIL back-to-back → ack high from cycle 1, pkt_done[0] pulse with pkt_len=4, flit_count=4, pkt_count=1, err_count=0.
- Channel 1 sends a BODY flit while IDLE, then HEAD|TAIL with dest=ID+1 → err_count=1, pkt_count=1, pkt_len[1]=1.
- Channel 2 sends HEAD, BODY, then HEAD (dest=ID+2), TAIL → err_count=1, pkt_count=1, pkt_len[2]=2.
- All 4 channels complete single-flit packets on the same edge, channel 3 with wrong dest → pkt_done=4'b1111, pkt_count +4, err_count +1.
- Packet of 70 flits with LEN_BITS=6 → pkt_len=63 (saturated), flit_count=70. Then clear=1 with a flit pending → counters 0 on the next cycle and ch_ack low for one cycle.
- enable dropped mid-packet for 5 cycles, then restored → no transfers while stalled, packet completes with the correct length. With PACKET_SINK_THROTTLE_EN defined, a 1000-flit stream completes with no loss and ack duty cycle ≈ 75%.

Source files
------------

// File: rtl/packet_sink_mc.sv
// Multi-channel NoC packet sink: per-channel framing FSM, destination check, packet-length report and aggregate counters.
// Optional ack throttling with per-channel LFSRs is enabled by defining PACKET_SINK_THROTTLE_EN.
module packet_sink_mc #(
  parameter int CHANNELS  = 4,
  parameter int ID        = 0,
  parameter int SIZE      = 8,
  parameter int DEST_BITS = 4,
  parameter int LEN_BITS  = 6,
  parameter int CNT_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [CHANNELS-1:0]          ch_req,
  input  logic [CHANNELS*SIZE-1:0]     ch_flit,
  output logic [CHANNELS-1:0]          ch_ack,
  output logic [CHANNELS-1:0]          pkt_done,
  output logic [CHANNELS*LEN_BITS-1:0] pkt_len,
  output logic [CNT_BITS-1:0]          pkt_count,
  output logic [CNT_BITS-1:0]          flit_count,
  output logic [CNT_BITS-1:0]          err_count
);

  localparam int NUM_W = $clog2(CHANNELS + 1);
  localparam int ERR_W = $clog2(2 * CHANNELS + 1);

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  function automatic logic [LEN_BITS-1:0] sat_inc(input logic [LEN_BITS-1:0] a);
    return (a == '1) ? a : a + LEN_BITS'(1);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                  input logic [ERR_W-1:0] b);
    logic [CNT_BITS:0] s;
    s = {1'b0, a} + (CNT_BITS + 1)'(b);
    return s[CNT_BITS] ? '1 : s[CNT_BITS-1:0];
  endfunction

  logic [CHANNELS-1:0] r_ack;
  logic [CHANNELS-1:0] r_done;
  logic [CHANNELS-1:0] w_xfer;
  logic [CHANNELS-1:0] w_throttle;
  logic [CHANNELS-1:0] w_done;
  logic [1:0]          w_err [CHANNELS];
  logic [CNT_BITS-1:0] r_pkt_cnt, r_flit_cnt, r_err_cnt;
  logic [NUM_W-1:0]    w_nflit, w_npkt;
  logic [ERR_W-1:0]    w_nerr;
  logic                w_unused_flit;

  // Only head/tail/dest bits carry meaning; the rest of each flit is payload we ignore.
  assign w_unused_flit = ^ch_flit;
  assign w_xfer        = ch_req & r_ack;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      localparam logic [DEST_BITS-1:0] DEST_EXP = DEST_BITS'(ID + g);

      state_t              r_state, w_state_nxt;
      logic [LEN_BITS-1:0] r_len, w_len_nxt, r_pkt_len;
      logic                w_head, w_tail, w_miss, w_done_ch;
      logic [1:0]          w_err_ch;

      assign w_head = ch_flit[g*SIZE + SIZE - 1];
      assign w_tail = ch_flit[g*SIZE + SIZE - 2];
      assign w_miss = w_head & (ch_flit[g*SIZE +: DEST_BITS] != DEST_EXP);

      // A misrouted head flit is still tracked; its error adds to any framing error.
      always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_done_ch   = 1'b0;
        w_err_ch    = {1'b0, w_xfer[g] & w_miss};
        if (w_xfer[g]) begin
          case (r_state)
            IDLE: begin
              if (w_head) begin
                w_len_nxt = LEN_BITS'(1);
                if (w_tail) w_done_ch = 1'b1;
                else        w_state_nxt = BODY;
              end else begin
                w_err_ch = 2'd1;
              end
            end
            BODY: begin
              if (w_head) begin
                w_err_ch  = w_err_ch + 2'd1;
                w_len_nxt = LEN_BITS'(1);
              end else begin
                w_len_nxt = sat_inc(r_len);
              end
              if (w_tail) begin
                w_done_ch   = 1'b1;
                w_state_nxt = IDLE;
              end
            end
            default: w_state_nxt = IDLE;
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_state   <= IDLE;
          r_len     <= '0;
          r_pkt_len <= '0;
          r_done[g] <= 1'b0;
        end else if (clear) begin
          r_state   <= IDLE;
          r_len     <= '0;
          r_pkt_len <= '0;
          r_done[g] <= 1'b0;
        end else begin
          r_state   <= w_state_nxt;
          r_len     <= w_len_nxt;
          r_done[g] <= w_done_ch;
          if (w_done_ch) r_pkt_len <= w_len_nxt;
        end
      end

      assign w_done[g]                         = w_done_ch;
      assign w_err[g]                          = w_err_ch;
      assign pkt_len[g*LEN_BITS +: LEN_BITS]   = r_pkt_len;

`ifdef PACKET_SINK_THROTTLE_EN
      localparam logic [7:0] SEED = 8'(((ID + g) % 255) + 1);
      logic [7:0] r_lfsr;

      // Fibonacci LFSR, taps 8,6,5,4; free-running regardless of enable/clear.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= SEED;
        else        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end

      assign w_throttle[g] = (r_lfsr[1:0] == 2'b00);
`else
      assign w_throttle[g] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    w_nflit = '0;
    w_npkt  = '0;
    w_nerr  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_nflit = w_nflit + NUM_W'(w_xfer[i]);
      w_npkt  = w_npkt + NUM_W'(w_done[i]);
      w_nerr  = w_nerr + ERR_W'(w_err[i]);
    end
  end

  // Ack is registered and independent of ch_req so upstream sees a clean ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack      <= '0;
      r_pkt_cnt  <= '0;
      r_flit_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_ack <= {CHANNELS{enable & ~clear}} & ~w_throttle;
      if (clear) begin
        r_pkt_cnt  <= '0;
        r_flit_cnt <= '0;
        r_err_cnt  <= '0;
      end else begin
        r_pkt_cnt  <= r_pkt_cnt + CNT_BITS'(w_npkt);
        r_flit_cnt <= r_flit_cnt + CNT_BITS'(w_nflit);
        r_err_cnt  <= sat_add(r_err_cnt, w_nerr);
      end
    end
  end

  assign ch_ack     = r_ack;
  assign pkt_done   = r_done;
  assign pkt_count  = r_pkt_cnt;
  assign flit_count = r_flit_cnt;
  assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_packet_sink_mc.sv
// Scoreboard bench for packet_sink_mc: directed packets push expected completions, a monitor checks pkt_done/pkt_len.
module tb_packet_sink_mc;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  ch_req = '0;
  logic [31:0] ch_flit = '0;
  logic [3:0]  ch_ack, pkt_done;
  logic [23:0] pkt_len;
  logic [15:0] pkt_count, flit_count, err_count;

  packet_sink_mc #(.CHANNELS(4), .ID(0), .SIZE(8), .DEST_BITS(4), .LEN_BITS(6), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .ch_req(ch_req), .ch_flit(ch_flit), .ch_ack(ch_ack), .pkt_done(pkt_done),
    .pkt_len(pkt_len), .pkt_count(pkt_count), .flit_count(flit_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [5:0] len;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic chk_cnt(input string tag, input int p, input int f, input int e);
    check({tag, "_pkt_count"}, 32'(pkt_count), 32'(p));
    check({tag, "_flit_count"}, 32'(flit_count), 32'(f));
    check({tag, "_err_count"}, 32'(err_count), 32'(e));
  endtask

  function automatic logic [7:0] fl(input logic h, input logic t, input logic [3:0] d);
    return {h, t, 2'b00, d};
  endfunction

  // Issue flits on the masked channels; each channel drops req once its transfer edge has passed.
  task automatic xfer(input logic [3:0] m, input logic [31:0] f);
    logic [3:0] pend, a;
    int t;
    pend = m;
    t = 0;
    for (int i = 0; i < 4; i++)
      if (m[i]) ch_flit[i*8 +: 8] = f[i*8 +: 8];
    ch_req = pend;
    while (pend != 4'b0 && t < 50) begin
      @(negedge clk);
      a = ch_ack & pend;
      @(posedge clk);
      #1;
      pend = pend & ~a;
      ch_req = pend;
      t++;
    end
    if (pend != 4'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL xfer_timeout: pending %b required 0000", pend);
      ch_req = '0;
    end
  endtask

  task automatic send1(input int ch, input logic [7:0] f);
    xfer(4'(1 << ch), {4{f}});
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        if (pkt_done[i]) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: channel %0d pulsed, required no pulse", i);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("done_channel", 32'(i), 32'(e.ch));
            check("pkt_len", 32'(pkt_len[i*6 +: 6]), 32'(e.len));
          end
        end
      end
    end
  end

  initial begin
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ch_ack), 32'(0));
    check("rst_pkt_done", 32'(pkt_done), 32'(0));
    check("rst_pkt_len", 32'(pkt_len), 32'(0));
    chk_cnt("rst", 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
`ifndef PACKET_SINK_THROTTLE_EN
    check("ack_after_reset", 32'(ch_ack), 32'hF);
`endif

    // Four-flit packet on channel 0
    sb_q.push_back('{ch: 2'd0, len: 6'd4});
    send1(0, fl(1, 0, 4'd0));
    send1(0, fl(0, 0, 4'd0));
    send1(0, fl(0, 0, 4'd0));
    send1(0, fl(0, 1, 4'd0));
    chk_cnt("s1", 1, 4, 0);
    clear_pulse();
    chk_cnt("s1_clear", 0, 0, 0);
    check("s1_clear_len", 32'(pkt_len), 32'(0));

    // Stray body flit while idle, then a single-flit packet on channel 1
    sb_q.push_back('{ch: 2'd1, len: 6'd1});
    send1(1, fl(0, 0, 4'd1));
    send1(1, fl(1, 1, 4'd1));
    chk_cnt("s2", 1, 2, 1);
    clear_pulse();

    // Truncated packet on channel 2: new head restarts length
    sb_q.push_back('{ch: 2'd2, len: 6'd2});
    send1(2, fl(1, 0, 4'd2));
    send1(2, fl(0, 0, 4'd2));
    send1(2, fl(1, 0, 4'd2));
    send1(2, fl(0, 1, 4'd2));
    chk_cnt("s3", 1, 4, 1);
    clear_pulse();

    // All channels complete on one edge; channel 3 misrouted
    for (int i = 0; i < 4; i++) sb_q.push_back('{ch: 2'(i), len: 6'd1});
    xfer(4'hF, {fl(1, 1, 4'd5), fl(1, 1, 4'd2), fl(1, 1, 4'd1), fl(1, 1, 4'd0)});
`ifndef PACKET_SINK_THROTTLE_EN
    check("s4_done_all", 32'(pkt_done), 32'hF);
`endif
    chk_cnt("s4", 4, 4, 1);
    @(posedge clk);
    #1;
    check("s4_done_pulse_end", 32'(pkt_done), 32'(0));
    clear_pulse();

    // 70-flit packet saturates the 6-bit length
    sb_q.push_back('{ch: 2'd0, len: 6'd63});
    send1(0, fl(1, 0, 4'd0));
    for (int k = 0; k < 68; k++) send1(0, fl(0, 0, 4'd0));
    send1(0, fl(0, 1, 4'd0));
    chk_cnt("s5", 1, 70, 0);

    // Clear with a head flit pending: consumed, not counted, FSM left idle
    ch_flit[7:0] = fl(1, 0, 4'd0);
    ch_req = 4'b0001;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    ch_req = '0;
    chk_cnt("s5_clear", 0, 0, 0);
    check("s5_clear_len", 32'(pkt_len), 32'(0));
`ifndef PACKET_SINK_THROTTLE_EN
    check("s5_clear_ack_low", 32'(ch_ack), 32'(0));
    @(posedge clk);
    #1;
    check("s5_ack_back", 32'(ch_ack), 32'hF);
`endif
    send1(0, fl(0, 0, 4'd0));
    chk_cnt("s5_idle_after_clear", 0, 1, 1);
    clear_pulse();

    // Stall mid-packet on channel 3 for five cycles
    sb_q.push_back('{ch: 2'd3, len: 6'd4});
    send1(3, fl(1, 0, 4'd3));
    send1(3, fl(0, 0, 4'd3));
    enable = 1'b0;
    @(posedge clk);
    #1;
    ch_flit[31:24] = fl(0, 0, 4'd3);
    ch_req = 4'b1000;
    repeat (5) @(posedge clk);
    #1;
    check("s6_stall_flits", 32'(flit_count), 32'(2));
    check("s6_stall_ack", 32'(ch_ack), 32'(0));
    enable = 1'b1;
    send1(3, fl(0, 0, 4'd3));
    send1(3, fl(0, 1, 4'd3));
    chk_cnt("s6", 1, 4, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
